// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store memory-access stage.
//   lsu_state_t : FSM states of lsu_mem_access
//   BE_WORD     : byte-enable pattern for a full-word access
//   ALIGN_MASK  : address bits that must be zero for a word access
//   is_aligned  : true when the low address bits describe a word boundary
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2
    } lsu_state_t;

    localparam logic [3:0] BE_WORD    = 4'hF;
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    function automatic logic is_aligned(input logic [1:0] lo);
        return (lo & ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/lsu_timeout_ctr.sv
// Response timeout counter for the memory-access stage.
//   addr_clk  in  clock
//   addr_rst  in  asynchronous active-low reset
//   clear     in  restart the count at zero
//   enable    in  advance the count by one this cycle
//   expired   out count has reached TIMEOUT_CYCLES-1
module lsu_timeout_ctr #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic addr_clk,
    input  logic addr_rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    // Holds at LAST so the counter never wraps back into a live range.
    always_ff @(posedge addr_clk or negedge addr_rst) begin
        if (!addr_rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/lsu_mem_access.sv
// Memory-access stage after the load/store address generator.
// Checks word alignment, runs a req/gnt/rvalid handshake to data memory,
// stalls the pipeline while a transaction is outstanding, and returns load
// data / destination register or reports misalignment and bus timeout.
//   addr_clk, addr_rst             clock, asynchronous active-low reset
//   addr, ld_valid, sd_valid       request from the address generator
//   st_data, ld_rd                 store data / load destination register
//   dmem_*                         data-memory request/response interface
//   ld_data, ld_data_valid, ld_rd_out   load result to writeback
//   st_done                        store completion pulse
//   lsu_busy                       pipeline stall request
//   misaligned_err, bus_err, err_addr   error pulses and faulting address
module lsu_mem_access
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned GPR_ADDR_WIDTH = 5,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                      addr_clk,
    input  logic                      addr_rst,
    input  logic [DATA_WIDTH-1:0]     addr,
    input  logic                      ld_valid,
    input  logic                      sd_valid,
    input  logic [DATA_WIDTH-1:0]     st_data,
    input  logic [GPR_ADDR_WIDTH-1:0] ld_rd,
    output logic                      dmem_req,
    output logic                      dmem_we,
    output logic [DATA_WIDTH-1:0]     dmem_addr,
    output logic [DATA_WIDTH-1:0]     dmem_wdata,
    output logic [3:0]                dmem_be,
    input  logic                      dmem_gnt,
    input  logic                      dmem_rvalid,
    input  logic [DATA_WIDTH-1:0]     dmem_rdata,
    output logic [DATA_WIDTH-1:0]     ld_data,
    output logic                      ld_data_valid,
    output logic [GPR_ADDR_WIDTH-1:0] ld_rd_out,
    output logic                      st_done,
    output logic                      lsu_busy,
    output logic                      misaligned_err,
    output logic                      bus_err,
    output logic [DATA_WIDTH-1:0]     err_addr
);

    lsu_state_t state_q, state_d;

    logic                      req_any, req_ok, accept, misalign;
    logic                      rsp_seen, timed_out, ctr_clear, ctr_en, expired;
    logic [DATA_WIDTH-1:0]     cap_addr, cap_wdata;
    logic                      cap_we;
    logic [GPR_ADDR_WIDTH-1:0] cap_rd;

    assign req_any   = ld_valid | sd_valid;
    assign req_ok    = is_aligned(addr[1:0]);
    assign accept    = (state_q == IDLE) && req_any && req_ok;
    assign misalign  = (state_q == IDLE) && req_any && !req_ok;
    assign rsp_seen  = (state_q == WAIT_RSP) && dmem_rvalid;
    // A response on the final waiting cycle takes priority over the timeout.
    assign timed_out = (state_q == WAIT_RSP) && !dmem_rvalid && expired;
    assign ctr_clear = (state_q == REQ) && dmem_gnt;
    assign ctr_en    = (state_q == WAIT_RSP);

    lsu_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .addr_clk (addr_clk),
        .addr_rst (addr_rst),
        .clear    (ctr_clear),
        .enable   (ctr_en),
        .expired  (expired)
    );

    always_ff @(posedge addr_clk or negedge addr_rst) begin
        if (!addr_rst) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // lsu_busy is gated by reset so every output reads 0 while reset is held,
    // even if upstream keeps a request asserted.
    always_comb begin
        state_d  = state_q;
        dmem_req = 1'b0;
        dmem_be  = '0;
        lsu_busy = addr_rst && (accept || (state_q != IDLE));
        unique case (state_q)
            IDLE:     if (accept) state_d = REQ;
            REQ: begin
                dmem_req = 1'b1;
                dmem_be  = BE_WORD;
                if (dmem_gnt) state_d = WAIT_RSP;
            end
            WAIT_RSP: if (rsp_seen || timed_out) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge addr_clk or negedge addr_rst) begin
        if (!addr_rst) begin
            cap_addr       <= '0;
            cap_wdata      <= '0;
            cap_we         <= 1'b0;
            cap_rd         <= '0;
            ld_data        <= '0;
            ld_rd_out      <= '0;
            ld_data_valid  <= 1'b0;
            st_done        <= 1'b0;
            misaligned_err <= 1'b0;
            bus_err        <= 1'b0;
            err_addr       <= '0;
        end else begin
            ld_data_valid  <= 1'b0;
            st_done        <= 1'b0;
            misaligned_err <= 1'b0;
            bus_err        <= 1'b0;
            if (accept) begin
                // Load wins when both valids are set; loads drive zero write data.
                cap_addr  <= {addr[DATA_WIDTH-1:2], 2'b00};
                cap_we    <= !ld_valid;
                cap_wdata <= ld_valid ? '0 : st_data;
                cap_rd    <= ld_rd;
            end
            if (misalign) begin
                misaligned_err <= 1'b1;
                err_addr       <= addr;
            end
            if (rsp_seen) begin
                if (cap_we) begin
                    st_done <= 1'b1;
                end else begin
                    ld_data_valid <= 1'b1;
                    ld_data       <= dmem_rdata;
                    ld_rd_out     <= cap_rd;
                end
            end
            if (timed_out) begin
                bus_err  <= 1'b1;
                err_addr <= cap_addr;
            end
        end
    end

    assign dmem_addr  = cap_addr;
    assign dmem_we    = cap_we;
    assign dmem_wdata = cap_wdata;

endmodule
